// File: rtl/iopad_bank_ctrl_if.sv
// Pad-bank signal bundle: core-side controls, pad vectors and status.
// master = core/pad environment, slave = iopad_bank_ctrl.
interface iopad_bank_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int FILT_W = 4
);
    logic [WIDTH-1:0]  dout_i;
    logic [WIDTH-1:0]  dir_i;
    logic [WIDTH-1:0]  filt_en_i;
    logic [FILT_W-1:0] filt_len_i;
    logic [WIDTH-1:0]  ies_i;
    logic [WIDTH-1:0]  ie_i;
    logic [WIDTH-1:0]  ifg_clr_i;
    logic [WIDTH-1:0]  pad_i;
    logic [WIDTH-1:0]  pad_o;
    logic [WIDTH-1:0]  pad_oe;
    logic [WIDTH-1:0]  din_o;
    logic [WIDTH-1:0]  ifg_o;
    logic              irq_o;

    modport master (
        output dout_i, dir_i, filt_en_i, filt_len_i,
        output ies_i, ie_i, ifg_clr_i, pad_i,
        input  pad_o, pad_oe, din_o, ifg_o, irq_o
    );

    modport slave (
        input  dout_i, dir_i, filt_en_i, filt_len_i,
        input  ies_i, ie_i, ifg_clr_i, pad_i,
        output pad_o, pad_oe, din_o, ifg_o, irq_o
    );
endinterface

// File: rtl/iopad_bank_ctrl.sv
// GPIO pad bank: registered output path, input synchroniser,
// per-channel glitch filter and edge-interrupt flags.
module iopad_bank_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input logic               mclk,
    input logic               puc_rst,
    iopad_bank_ctrl_if.slave  bus
);
    localparam int CW = FILT_W + 1;

    logic [WIDTH-1:0]  pad_o_q, pad_o_d;
    logic [WIDTH-1:0]  pad_oe_q, pad_oe_d;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_d [SYNC_STAGES];
    logic [FILT_W-1:0] cnt_q [WIDTH];
    logic [FILT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]  din_q, din_d;
    logic [WIDTH-1:0]  ifg_q, ifg_d;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  rise, fall;
    logic [CW-1:0]     leff;

    assign x = sync_q[SYNC_STAGES-1];

    always_comb begin
        pad_o_d  = bus.dout_i;
        pad_oe_d = bus.dir_i;
        sync_d[0] = bus.pad_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // A zero threshold behaves as one: no extra delay over the synchroniser.
    always_comb begin
        leff = (bus.filt_len_i == '0) ? CW'(1) : CW'(bus.filt_len_i);
    end

    // Counter is compared one bit wider so cnt+1 can never wrap.
    always_comb begin
        din_d = din_q;
        for (int c = 0; c < WIDTH; c++) begin
            cnt_d[c] = '0;
            if (!bus.filt_en_i[c]) begin
                din_d[c] = x[c];
            end else if (x[c] == din_q[c]) begin
                cnt_d[c] = '0;
            end else if (({1'b0, cnt_q[c]} + CW'(1)) >= leff) begin
                din_d[c] = x[c];
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    // Set beats a same-cycle clear so no edge is lost.
    always_comb begin
        rise  = ~din_q & din_d;
        fall  = din_q & ~din_d;
        ifg_d = (ifg_q & ~bus.ifg_clr_i) |
                ((bus.ies_i & fall) | (~bus.ies_i & rise));
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            pad_o_q  <= '0;
            pad_oe_q <= '0;
            din_q    <= '0;
            ifg_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int c = 0; c < WIDTH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            pad_o_q  <= pad_o_d;
            pad_oe_q <= pad_oe_d;
            din_q    <= din_d;
            ifg_q    <= ifg_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pad_o  = pad_o_q;
    assign bus.pad_oe = pad_oe_q;
    assign bus.din_o  = din_q;
    assign bus.ifg_o  = ifg_q;
    assign bus.irq_o  = |(ifg_q & bus.ie_i);
endmodule

// File: doc/iopad_bank_ctrl.md
# iopad_bank_ctrl

Parametrised bidirectional pad-bank controller between the core peripherals and the per-bit input/output pad vectors. It registers output data and output enable toward the pads, resynchronises pad inputs into the `mclk` domain, and rejects glitches with a per-channel programmable digital filter. It also raises per-channel edge-interrupt flags. One instance serves a whole GPIO port of `WIDTH` channels.

## Interface
Parameters:
- `WIDTH`, 8: number of pad channels.
- `SYNC_STAGES`, 2: input synchroniser depth. Legal range is 2..4.
- `FILT_W`, 4: width of the filter-length field and of each per-channel filter counter.

Ports:
- `mclk`, in, 1: the block's only clock. All state changes on its rising edge.
- `puc_rst`, in, 1: reset. Asynchronous and active-high.
- `dout_i`, in, `WIDTH`: output data from the core.
- `dir_i`, in, `WIDTH`: direction per channel. 1 = drive, 0 = input only.
- `filt_en_i`, in, `WIDTH`: enables the glitch filter per channel.
- `filt_len_i`, in, `FILT_W`: filter threshold L, shared by all channels.
- `ies_i`, in, `WIDTH`: edge select per channel. 0 = rising edge, 1 = falling edge.
- `ie_i`, in, `WIDTH`: interrupt enable per channel.
- `ifg_clr_i`, in, `WIDTH`: one-cycle strobe that clears the flag.
- `pad_i`, in, `WIDTH`: raw value from the input pads. Asynchronous.
- `pad_o`, out, `WIDTH`: registered data to the output pads.
- `pad_oe`, out, `WIDTH`: registered output enable.
- `din_o`, out, `WIDTH`: synchronised, filtered input value.
- `ifg_o`, out, `WIDTH`: edge-interrupt flags.
- `irq_o`, out, 1: combined interrupt request.

## Operation
- **Output path**
  - `pad_o` <= `dout_i` and `pad_oe` <= `dir_i` on every edge.
  - No other logic on this path.
- **Synchroniser**
  - Per channel, a chain s[0..SYNC_STAGES-1] with s[0] <= `pad_i`.
  - The synchroniser runs regardless of `dir_i`, so output channels read back their own pad value.
- **Filter**
  - Per channel: counter `cnt` (`FILT_W` bits) and state `din` (= `din_o`). Let x = s[last] and Leff = max(L,1).
  - If `filt_en_i`=0: `din` <= x and `cnt` <= 0.
  - Else, if x == `din`: `cnt` <= 0.
  - Else, if `cnt`+1 >= Leff: `din` <= x and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Comparison uses `>=`. If L is lowered mid-count, a pending transition completes on the next mismatching edge. `cnt` never wraps.
- **Edge detect**
  - rise = ~`din` & next_din; fall = `din` & ~next_din.
  - set = (`ies_i` ? fall : rise). It is evaluated on the edge where `din` changes.
  - `ifg` <= (`ifg` & ~`ifg_clr_i`) | set. Set wins over a simultaneous clear.
- **Interrupt**
  - `irq_o` = |(`ifg_o` & `ie_i`), combinational from registers.
  - `ie_i` gates only `irq_o`, never flag setting.
- **Reset** (asynchronous, mid-operation included)
  - `pad_o`, `pad_oe`, `din_o`, `ifg_o`, all sync stages and all counters go to 0.
  - `irq_o` = 0.
  - After release, a pad held at 1 produces `din_o`=1 and sets `ifg` for channels with `ies_i`=0. This is required: power-up rising edges are visible.

## Timing
- Output latency: 1 edge from `dout_i`/`dir_i` to `pad_o`/`pad_oe`.
- Input latency, filter disabled: a `pad_i` level sampled at edge k appears on `din_o` after edge k+SYNC_STAGES.
- Input latency, filter enabled: edge k+SYNC_STAGES+Leff-1.
  - The first mismatch edge counts as 1.
  - This assumes x stays stable.
- Glitch rejection:
  - An x pulse shorter than Leff cycles never changes `din_o` and never sets `ifg`.
  - An x pulse of exactly Leff cycles passes.
- `ifg_o` rises in the same cycle as the `din_o` transition. `irq_o` follows in the same cycle.
- Channels are fully independent. Simultaneous events on different channels are each handled.

## Test plan
- **Reset:** assert `puc_rst` asynchronously between edges with `pad_i`=8'hFF and `dout_i`=8'hA5 -> all outputs read 0 immediately, before the next `mclk` edge.
- **Output and readback:** `dout_i`=8'h3C, `dir_i`=8'hF0, `pad_i`=8'h3C -> one edge later `pad_o`=8'h3C and `pad_oe`=8'hF0. `din_o`=8'h3C after 2 more edges (SYNC_STAGES=2, filter off).
- **Filter:** ch0 with L=4, filter enabled.
  - A 3-cycle high pulse on `pad_i`[0] -> `din_o`[0] stays 0 and `ifg_o`[0] stays 0.
  - A 4-cycle pulse -> `din_o`[0] rises exactly 2+3 edges after the first sampled high, then falls after the pulse by the same rule.
- **L=0 and L=1:** identical latency to filter-disabled (SYNC_STAGES edges).
- **Edge select and IRQ:** `ies_i`[1]=1, `ie_i`[1]=1, falling edge on ch1 -> `ifg_o`[1]=1 and `irq_o`=1. A rising edge on ch1 does not set the flag.
- **Set/clear race:** `ifg_clr_i`[2] pulses on the same edge that a new edge sets ch2 -> `ifg_o`[2] remains 1. A clear alone drops it to 0 and `irq_o` falls in the same cycle.
